ifetch: RTL



---
 rtl/ifetch.sv | 107 ++++++++++
 1 files changed

// File: rtl/ifetch.sv
// ifetch: instruction fetch with single-outstanding memory handshake, 2-entry prefetch queue and redirect
module ifetch #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_rd,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_taken,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] fpc, fpc_n, addr, addr_n;
  logic [WIDTH-1:0] d0, d1, p0, p1, d0_n, d1_n, p0_n, p1_n;
  logic v0, v1, v0_n, v1_n, pop, push;
  assign mem_rd     = state != IDLE;
  assign mem_addr   = addr;
  assign inst_valid = v0;
  assign inst       = d0;
  assign inst_pc    = p0;
  always_comb begin
    pop  = inst_taken && v0 && !redirect;
    push = state == REQ && mem_ack && !redirect;
    v0_n = pop ? v1 : v0;
    d0_n = pop ? d1 : d0;
    p0_n = pop ? p1 : p0;
    v1_n = pop ? 1'b0 : v1;
    d1_n = d1;
    p1_n = p1;
    if (push && !v0_n) begin
      v0_n = 1'b1;
      d0_n = mem_rdata;
      p0_n = addr;
    end else if (push) begin
      v1_n = 1'b1;
      d1_n = mem_rdata;
      p1_n = addr;
    end
    if (redirect) begin
      v0_n = 1'b0;
      v1_n = 1'b0;
    end
    state_n = state;
    fpc_n   = fpc;
    addr_n  = addr;
    case (state)
      IDLE: begin
        if (redirect) begin
          state_n = REQ;
          fpc_n   = redirect_pc;
          addr_n  = redirect_pc;
        end else if (!(v0_n && v1_n)) begin
          state_n = REQ;
          addr_n  = fpc;
        end
      end
      REQ: begin
        if (redirect) begin
          fpc_n   = redirect_pc;
          addr_n  = mem_ack ? redirect_pc : addr;
          state_n = mem_ack ? REQ : DROP;
        end else if (mem_ack) begin
          fpc_n   = addr + WIDTH'(1);
          addr_n  = addr + WIDTH'(1);
          state_n = (v0_n && v1_n) ? IDLE : REQ;
        end
      end
      DROP: begin
        fpc_n   = redirect ? redirect_pc : fpc;
        addr_n  = mem_ack ? fpc_n : addr;
        state_n = mem_ack ? REQ : DROP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fpc   <= RESET_PC;
      addr  <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
      d0    <= '0;
      d1    <= '0;
      p0    <= '0;
      p1    <= '0;
    end else begin
      state <= state_n;
      fpc   <= fpc_n;
      addr  <= addr_n;
      v0    <= v0_n;
      v1    <= v1_n;
      d0    <= d0_n;
      d1    <= d1_n;
      p0    <= p0_n;
      p1    <= p1_n;
    end
  end
endmodule
